// File: rtl/timer_counter.sv
`default_nettype none
// ============================================================================
// timer_counter : BCD MM:SS kitchen-timer register with a 1 s countdown prescaler.
// Optional build macro TIMER_SEC_CARRY_EN: a seconds wrap in SET carries into minutes.
// Revision: 1.0
// ============================================================================
module timer_counter #(
  parameter int TICK_DIV = 100_000_000,
  parameter int MAX_MIN  = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enableCounter,
  input  logic       forward,
  input  logic       resetTimer,
  input  logic       incrementSeg,
  input  logic       incrementMin,
  output logic [3:0] segUnits,
  output logic [3:0] segTens,
  output logic [3:0] minUnits,
  output logic [3:0] minTens,
  output logic       finish,
  output logic       tick
);

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]    MIN_LAST   = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

  logic [7:0]    sec_q, sec_d;
  logic [7:0]    min_q, min_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          inc_seg_q, inc_seg_d;
  logic          inc_min_q, inc_min_d;

  logic set_mode, count_mode, seg_edge, min_edge;

  function automatic logic [7:0] min_inc(input logic [7:0] m);
    if (m == MIN_LAST)          return 8'h00;
    else if (m[3:0] == 4'd9)    return {m[7:4] + 4'd1, 4'd0};
    else                        return {m[7:4], m[3:0] + 4'd1};
  endfunction

  always_comb begin
    set_mode   = enableCounter & forward;
    count_mode = enableCounter & ~forward;
    seg_edge   = incrementSeg & ~inc_seg_q;
    min_edge   = incrementMin & ~inc_min_q;

    sec_d     = sec_q;
    min_d     = min_q;
    presc_d   = presc_q;
    tick_d    = 1'b0;
    inc_seg_d = incrementSeg;
    inc_min_d = incrementMin;

    if (reset) begin
      sec_d     = 8'h00;
      min_d     = 8'h00;
      presc_d   = '0;
      inc_seg_d = 1'b0;
      inc_min_d = 1'b0;
    end else if (resetTimer) begin
      sec_d   = 8'h00;
      min_d   = 8'h00;
      presc_d = '0;
    end else if (set_mode) begin
      presc_d = '0;
      if (seg_edge) begin
        if (sec_q == 8'h59)            sec_d = 8'h00;
        else if (sec_q[3:0] == 4'd9)   sec_d = {sec_q[7:4] + 4'd1, 4'd0};
        else                           sec_d = {sec_q[7:4], sec_q[3:0] + 4'd1};
`ifdef TIMER_SEC_CARRY_EN
        if (sec_q == 8'h59)            min_d = min_inc(min_d);
`endif
      end
      if (min_edge) min_d = min_inc(min_d);
    end else if (count_mode) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
        // 00:00 saturates; otherwise borrow from minutes when seconds are 00
        if (sec_q != 8'h00) begin
          sec_d = (sec_q[3:0] == 4'd0) ? {sec_q[7:4] - 4'd1, 4'd9}
                                       : {sec_q[7:4], sec_q[3:0] - 4'd1};
        end else if (min_q != 8'h00) begin
          sec_d = 8'h59;
          min_d = (min_q[3:0] == 4'd0) ? {min_q[7:4] - 4'd1, 4'd9}
                                       : {min_q[7:4], min_q[3:0] - 4'd1};
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    sec_q     <= sec_d;
    min_q     <= min_d;
    presc_q   <= presc_d;
    tick_q    <= tick_d;
    inc_seg_q <= inc_seg_d;
    inc_min_q <= inc_min_d;
  end

  assign segUnits = sec_q[3:0];
  assign segTens  = sec_q[7:4];
  assign minUnits = min_q[3:0];
  assign minTens  = min_q[7:4];
  assign tick     = tick_q;
  assign finish   = enableCounter & ~forward & (sec_q == 8'h00) & (min_q == 8'h00);

endmodule
`default_nettype wire

// File: tb/tb_timer_counter.sv
`default_nettype none
// ============================================================================
// tb_timer_counter : directed scenarios plus random stimulus against an integer MM:SS model.
// Revision: 1.0
// ============================================================================
module tb_timer_counter;

  localparam int TICK_DIV = 4;
  localparam int MAX_MIN  = 59;

  logic       clk = 1'b0;
  logic       reset, enableCounter, forward, resetTimer, incrementSeg, incrementMin;
  logic [3:0] segUnits, segTens, minUnits, minTens;
  logic       finish, tick;

  int checks   = 0;
  int failures = 0;

  timer_counter #(.TICK_DIV(TICK_DIV), .MAX_MIN(MAX_MIN)) dut (
    .clk(clk), .reset(reset), .enableCounter(enableCounter), .forward(forward),
    .resetTimer(resetTimer), .incrementSeg(incrementSeg), .incrementMin(incrementMin),
    .segUnits(segUnits), .segTens(segTens), .minUnits(minUnits), .minTens(minTens),
    .finish(finish), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] disp();
    return {minTens, minUnits, segTens, segUnits};
  endfunction

  // Reference model: time as plain integers, edge history as the previous levels
  int m_mm = 0, m_ss = 0, m_pre = 0;
  bit m_tick = 0, m_pseg = 0, m_pmin = 0, started = 0;

  always @(posedge clk) begin
    bit se, me;
    int total;
    se = incrementSeg && !m_pseg;
    me = incrementMin && !m_pmin;
    m_tick = 0;
    started = 1;
    if (reset) begin
      m_mm = 0; m_ss = 0; m_pre = 0; m_pseg = 0; m_pmin = 0;
    end else begin
      m_pseg = incrementSeg;
      m_pmin = incrementMin;
      if (resetTimer) begin
        m_mm = 0; m_ss = 0; m_pre = 0;
      end else if (enableCounter && forward) begin
        m_pre = 0;
        if (se) begin
          if (m_ss == 59) begin
            m_ss = 0;
`ifdef TIMER_SEC_CARRY_EN
            m_mm = (m_mm + 1) % (MAX_MIN + 1);
`endif
          end else m_ss = m_ss + 1;
        end
        if (me) m_mm = (m_mm + 1) % (MAX_MIN + 1);
      end else if (enableCounter) begin
        if (m_pre == TICK_DIV - 1) begin
          m_pre = 0;
          m_tick = 1;
          total = m_mm * 60 + m_ss;
          if (total > 0) total = total - 1;
          m_mm = total / 60;
          m_ss = total % 60;
        end else m_pre = m_pre + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("model_digits", {16'h0, disp()},
            {16'h0, 4'(m_mm / 10), 4'(m_mm % 10), 4'(m_ss / 10), 4'(m_ss % 10)});
      check("model_tick", {31'h0, tick}, {31'h0, m_tick});
      check("model_finish", {31'h0, finish},
            {31'h0, enableCounter && !forward && m_mm == 0 && m_ss == 0});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_seg(input int n);
    for (int i = 0; i < n; i++) begin
      incrementSeg = 1'b1; cyc(1);
      incrementSeg = 1'b0; cyc(1);
    end
  endtask

  task automatic pulse_min(input int n);
    for (int i = 0; i < n; i++) begin
      incrementMin = 1'b1; cyc(1);
      incrementMin = 1'b0; cyc(1);
    end
  endtask

  task automatic clear_timer();
    resetTimer = 1'b1; cyc(1);
    resetTimer = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enableCounter = 1'b0; forward = 1'b0; resetTimer = 1'b0;
    incrementSeg = 1'b1; incrementMin = 1'b1;
    cyc(2);
    check("reset_digits", {16'h0, disp()}, 32'h0);
    check("reset_tick", {31'h0, tick}, 32'h0);
    check("reset_finish", {31'h0, finish}, 32'h0);
    reset = 1'b0;
    cyc(1);
    // Increment levels left high from the FSM's initial state must not count
    enableCounter = 1'b1; forward = 1'b1;
    cyc(3);
    check("init_levels", {16'h0, disp()}, 32'h0);
    incrementSeg = 1'b0; incrementMin = 1'b0;
    cyc(1);

    pulse_seg(3);
    pulse_min(2);
    check("set_0203", {16'h0, disp()}, 32'h0203);
    incrementSeg = 1'b1; cyc(10);
    incrementSeg = 1'b0; cyc(1);
    check("held_level", {16'h0, disp()}, 32'h0204);

    clear_timer(); cyc(1);
    pulse_min(1);
    check("load_0100", {16'h0, disp()}, 32'h0100);
    forward = 1'b0;
    cyc(3);
    check("no_tick_yet", {31'h0, tick}, 32'h0);
    cyc(1);
    check("first_tick", {31'h0, tick}, 32'h1);
    check("dec_0059", {16'h0, disp()}, 32'h0059);
    check("finish_0059", {31'h0, finish}, 32'h0);

    cyc(2);
    enableCounter = 1'b0;
    cyc(10);
    check("hold_frozen", {16'h0, disp()}, 32'h0059);
    enableCounter = 1'b1;
    cyc(1);
    check("resume_no_tick", {31'h0, tick}, 32'h0);
    cyc(1);
    check("resume_tick", {31'h0, tick}, 32'h1);
    check("resume_0058", {16'h0, disp()}, 32'h0058);

    forward = 1'b1;
    clear_timer(); cyc(1);
    pulse_seg(2);
    check("load_0002", {16'h0, disp()}, 32'h0002);
    forward = 1'b0;
    cyc(4);
    check("cnt_0001", {16'h0, disp()}, 32'h0001);
    check("finish_0001", {31'h0, finish}, 32'h0);
    cyc(4);
    check("cnt_0000", {16'h0, disp()}, 32'h0000);
    check("finish_rise", {31'h0, finish}, 32'h1);
    cyc(3);
    check("finish_stays", {31'h0, finish}, 32'h1);
    enableCounter = 1'b0; #1;
    check("finish_drop", {31'h0, finish}, 32'h0);

    enableCounter = 1'b1; forward = 1'b1;
    cyc(1);
    clear_timer(); cyc(1);
    pulse_seg(59);
    check("load_0059", {16'h0, disp()}, 32'h0059);
    pulse_seg(1);
`ifdef TIMER_SEC_CARRY_EN
    check("sec_wrap", {16'h0, disp()}, 32'h0100);
`else
    check("sec_wrap", {16'h0, disp()}, 32'h0000);
`endif
    clear_timer(); cyc(1);
    pulse_min(59);
    check("load_5900", {16'h0, disp()}, 32'h5900);
    pulse_min(1);
    check("min_wrap", {16'h0, disp()}, 32'h0000);

    clear_timer(); cyc(1);
    pulse_min(5);
    pulse_seg(30);
    check("load_0530", {16'h0, disp()}, 32'h0530);
    forward = 1'b0;
    cyc(2);
    resetTimer = 1'b1; enableCounter = 1'b0;
    cyc(1);
    check("rt_clear", {16'h0, disp()}, 32'h0000);
    check("rt_finish", {31'h0, finish}, 32'h0);
    check("rt_tick", {31'h0, tick}, 32'h0);
    resetTimer = 1'b0; enableCounter = 1'b1;
    cyc(3);
    check("rt_no_tick", {31'h0, tick}, 32'h0);
    cyc(1);
    check("rt_full_period", {31'h0, tick}, 32'h1);

    for (int i = 0; i < 600; i++) begin
      reset         = ($urandom_range(0, 63) == 0);
      resetTimer    = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 7) == 0) enableCounter = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 5) == 0) forward       = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 2) == 0) incrementSeg  = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 3) == 0) incrementMin  = $urandom_range(0, 1) != 0;
      cyc(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
